mod_counter: RTL and testbench

Parametrised up/down modulo counter, the next-generation replacement for the fixed 4-bit free-running counter in the timing and sequencing datapath. It adds:

- a configurable width and modulus;
- direction control, synchronous clear and parallel load;
- wrap or saturate mode and an enable prescaler;
- terminal-count, wrap and overflow status outputs for formal and system checks.

It feeds event schedulers and timeout logic.

---
 rtl/mod_counter_pkg.sv | 38 +++
 rtl/mod_counter_tick_prescaler.sv | 50 +++++
 rtl/mod_counter.sv | 164 ++++++++++++++++
 tb/tb_mod_counter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//
// Shared definitions for the modulo counter and its prescaler.
//
// Contents:
//   CNT_WRAP / CNT_SAT : boundary behaviour selectors for the SATURATE
//                        parameter of mod_counter.
//   CNT_ARITH_W        : width of the generic helper arithmetic. It is wide
//                        enough for any legal WIDTH (up to 32) plus headroom.
//   presc_width()      : register width for a prescaler that counts
//                        0..PRESCALE-1. The result is never below 1 bit.
//   clamp_to_max()     : saturates a value to an upper bound.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int CNT_WRAP    = 0;
  localparam int CNT_SAT     = 1;
  localparam int CNT_ARITH_W = 64;

  // Width needed to hold 0..prescale-1.
  // A prescale of 1 or 2 still needs a single bit.
  function automatic int presc_width(input int prescale);
    if (prescale <= 2) begin
      return 1;
    end
    return $clog2(prescale);
  endfunction

  // Returns val when it lies within 0..max, otherwise max.
  function automatic logic [CNT_ARITH_W-1:0] clamp_to_max(
    input logic [CNT_ARITH_W-1:0] val,
    input logic [CNT_ARITH_W-1:0] max
  );
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//
// Divides the count enable by PRESCALE.
//
// The phase counter advances on every enabled cycle. It runs 0..PRESCALE-1
// and then returns to 0. It holds its value while en is low.
//
// tick is high on the enabled cycle that completes a full period.
// With PRESCALE=1 the phase register never leaves 0, so tick simply
// follows en.
//
// Ports:
//   clk     in  : rising-edge clock
//   rst     in  : synchronous active-high reset; phase returns to 0
//   restart in  : synchronous phase restart (clear or load in the parent)
//   en      in  : count enable
//   tick    out : combinational step strobe = en && phase == PRESCALE-1
// -----------------------------------------------------------------------------
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int            PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] r_phase;
  logic          w_last;

  assign w_last = (r_phase == LAST);
  assign tick   = en && w_last;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= w_last ? '0 : (r_phase + ONE);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Parametrised up/down modulo counter with the following features:
//   - prescaled enable
//   - synchronous clear
//   - parallel load with clamping
//   - wrap or saturate behaviour at the boundaries
//
// The count range is 0..MODULO-1, and MAX = MODULO-1.
//
// Per-cycle priority is rst > clr > load > step:
//   rst  : all state is cleared.
//   clr  : clears q, the prescaler, ovf and wrap.
//   load : q takes load_val, clamped to MAX. The prescale phase restarts.
//          ovf is unchanged.
//   step : q moves one position in the direction given by up.
//          At a boundary, q either wraps (wrap and ovf are set) or holds
//          (only ovf is set).
//
// Parameters:
//   WIDTH    : counter width, 2..32
//   MODULO   : number of count states, 2..2^WIDTH
//   SATURATE : CNT_WRAP (0) or CNT_SAT (1)
//   PRESCALE : enabled cycles per step, 1..256
//
// Ports:
//   clk      in  : rising-edge clock
//   rst      in  : synchronous active-high reset
//   clr      in  : synchronous clear of q, prescaler and ovf
//   load     in  : parallel load strobe
//   load_val in  : value to load (WIDTH bits)
//   en       in  : count enable, feeds the prescaler
//   up       in  : 1 = increment, 0 = decrement
//   q        out : registered count
//   tc       out : combinational terminal count, up ? q==MAX : q==0
//   wrap     out : registered pulse, high while q shows a wrapped value
//   ovf      out : registered sticky boundary-event flag
// -----------------------------------------------------------------------------
module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULO   = 16,
  parameter int     SATURATE = CNT_WRAP,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Arithmetic runs one bit wider than q. This keeps MAX+1 representable
  // when MODULO = 2^WIDTH, so an increment at MAX cannot alias back to 0
  // before the boundary test.
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULO - 1);
  localparam bit               SAT_MODE = (SATURATE == CNT_SAT);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_tick;
  logic             w_restart;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_inc_ext;
  logic [WIDTH:0]   w_dec_ext;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;

  // A clear or a load both restart the prescale phase. A step that the
  // prescaler reports in the same cycle is discarded by the priority
  // logic below.
  assign w_restart = clr || load;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .en      (en),
    .tick    (w_tick)
  );

  assign w_q_ext   = {1'b0, r_q};
  assign w_inc_ext = w_q_ext + ONE_EXT;
  // w_dec_ext is only used when q > 0, so it never underflows where
  // it matters.
  assign w_dec_ext = w_q_ext - ONE_EXT;
  assign w_at_max  = (w_q_ext == MAX_EXT);
  assign w_at_zero = (r_q == '0);

  // Out-of-range load values are clamped to the top of the count range.
  assign w_load_q = WIDTH'(clamp_to_max(CNT_ARITH_W'(load_val),
                                        CNT_ARITH_W'(MAX_Q)));

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    w_ovf_nxt  = r_ovf;

    if (clr) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (load) begin
      w_q_nxt = w_load_q;
    end else if (w_tick) begin
      if (up) begin
        if (!w_at_max) begin
          w_q_nxt = WIDTH'(w_inc_ext);
        end else begin
          w_ovf_nxt = 1'b1;
          if (!SAT_MODE) begin
            w_q_nxt    = '0;
            w_wrap_nxt = 1'b1;
          end
        end
      end else begin
        if (!w_at_zero) begin
          w_q_nxt = WIDTH'(w_dec_ext);
        end else begin
          w_ovf_nxt = 1'b1;
          if (!SAT_MODE) begin
            w_q_nxt    = MAX_Q;
            w_wrap_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;
  assign tc   = up ? (r_q == MAX_Q) : w_at_zero;

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//
// Four counter instances share one set of inputs:
//   0: MODULO=10, wrap,     PRESCALE=1
//   1: MODULO=10, saturate, PRESCALE=1
//   2: MODULO=10, wrap,     PRESCALE=3
//   3: MODULO=16, wrap,     PRESCALE=1
//
// A behavioural model tracks each instance with plain integer arithmetic.
// Scenario tasks also check hand-derived constants for the cases called out
// in the description.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  localparam int N = 4;

  // ---------------------------------------------------------------------------
  // Clock and stimulus signals
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      = 1'b0;
  logic       clr      = 1'b0;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en       = 1'b0;
  logic       up       = 1'b1;

  // ---------------------------------------------------------------------------
  // DUT outputs
  // ---------------------------------------------------------------------------
  logic [3:0] q0, q1, q2, q3;
  logic       t0, t1, t2, t3;
  logic       w0, w1, w2, w3;
  logic       o0, o1, o2, o3;

  logic [3:0] dq[N];
  logic       dtc[N];
  logic       dw[N];
  logic       dov[N];

  assign dq[0]  = q0;
  assign dq[1]  = q1;
  assign dq[2]  = q2;
  assign dq[3]  = q3;
  assign dtc[0] = t0;
  assign dtc[1] = t1;
  assign dtc[2] = t2;
  assign dtc[3] = t3;
  assign dw[0]  = w0;
  assign dw[1]  = w1;
  assign dw[2]  = w2;
  assign dw[3]  = w3;
  assign dov[0] = o0;
  assign dov[1] = o1;
  assign dov[2] = o2;
  assign dov[3] = o3;

  // ---------------------------------------------------------------------------
  // Device instances
  // ---------------------------------------------------------------------------
  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q0), .tc(t0), .wrap(w0), .ovf(o0));

  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q1), .tc(t1), .wrap(w1), .ovf(o1));

  mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q2), .tc(t2), .wrap(w2), .ovf(o2));

  mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .PRESCALE(1)) u_full (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q3), .tc(t3), .wrap(w3), .ovf(o3));

  // ---------------------------------------------------------------------------
  // Reference model: per-instance parameters and state
  // ---------------------------------------------------------------------------
  int p_max[N] = '{9, 9, 9, 15};
  int p_sat[N] = '{0, 1, 0, 0};
  int p_pre[N] = '{1, 1, 3, 1};

  int m_q[N];
  int m_pc[N];
  bit m_w[N];
  bit m_o[N];

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];

  // Advances the model by one clock edge, using the inputs applied
  // on that edge.
  task automatic model_edge();
    int lv;
    bit stepping;
    lv = int'(load_val);
    for (int i = 0; i < N; i++) begin
      stepping = 1'b0;
      if (rst || clr) begin
        m_q[i]  = 0;
        m_pc[i] = 0;
        m_w[i]  = 1'b0;
        m_o[i]  = 1'b0;
      end else if (load) begin
        m_q[i]  = (lv > p_max[i]) ? p_max[i] : lv;
        m_pc[i] = 0;
        m_w[i]  = 1'b0;
      end else begin
        m_w[i] = 1'b0;
        if (en) begin
          m_pc[i] = m_pc[i] + 1;
          if (m_pc[i] == p_pre[i]) begin
            m_pc[i]  = 0;
            stepping = 1'b1;
          end
        end
        if (stepping) begin
          if (up) begin
            if (m_q[i] < p_max[i]) begin
              m_q[i] = m_q[i] + 1;
            end else begin
              m_o[i] = 1'b1;
              if (p_sat[i] == 0) begin
                m_q[i] = 0;
                m_w[i] = 1'b1;
              end
            end
          end else begin
            if (m_q[i] > 0) begin
              m_q[i] = m_q[i] - 1;
            end else begin
              m_o[i] = 1'b1;
              if (p_sat[i] == 0) begin
                m_q[i] = p_max[i];
                m_w[i] = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  // Expected {q, wrap, ovf, tc} for instance i, given the model state
  // and the current value of up.
  function automatic logic [6:0] exp_vec(input int i);
    logic tcx;
    tcx = up ? (m_q[i] == p_max[i]) : (m_q[i] == 0);
    return {4'(m_q[i]), m_w[i], m_o[i], tcx};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Called at a falling edge. It applies the inputs, lets one rising edge
  // pass, updates the model and returns at the next falling edge.
  task automatic cyc(input bit r, input bit c, input bit l, input int lv,
                     input bit e, input bit u);
    rst      = r;
    clr      = c;
    load     = l;
    load_val = 4'(lv);
    en       = e;
    up       = u;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({dq[i], dw[i], dov[i], dtc[i]} !== 7'b0000_001) begin
        $display("FAIL reset inst%0d got q/wrap/ovf/tc=%h want=%h",
                 i, {dq[i], dw[i], dov[i], dtc[i]}, 7'b0000_001);
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic test_count();
    logic [3:0] e;
    for (int v = 1; v <= 12; v++) exp_q.push_back(4'(v % 10));
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 0, 0, 1, 1);
      e = exp_q.pop_front();
      n_checks++;
      if ({q0, w0, o0, t0} !== {e, (e == 4'd0), (k >= 10), (e == 4'd9)}) begin
        $display("FAIL count step%0d got q/wrap/ovf/tc=%h want=%h", k,
                 {q0, w0, o0, t0}, {e, (e == 4'd0), (k >= 10), (e == 4'd9)});
      end else begin
        n_pass++;
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if ({dq[i], dw[i], dov[i], dtc[i]} !== exp_vec(i)) begin
          $display("FAIL count_model inst%0d got %h want %h",
                   i, {dq[i], dw[i], dov[i], dtc[i]}, exp_vec(i));
        end else begin
          n_pass++;
        end
      end
    end
  endtask

  task automatic test_down_wrap();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({q0, t0} !== {4'd0, 1'b1}) begin
      $display("FAIL down_pre got q/tc=%h want=%h", {q0, t0}, {4'd0, 1'b1});
    end else begin
      n_pass++;
    end
    cyc(0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({q0, w0, o0, q1, w1, o1} !== {4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1}) begin
      $display("FAIL down_wrap got %h want %h", {q0, w0, o0, q1, w1, o1},
               {4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1});
    end else begin
      n_pass++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({dq[i], dw[i], dov[i], dtc[i]} !== exp_vec(i)) begin
        $display("FAIL down_model inst%0d got %h want %h",
                 i, {dq[i], dw[i], dov[i], dtc[i]}, exp_vec(i));
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic test_saturate();
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 9, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1, 1);
      n_checks++;
      if ({q1, w1, o1, t1} !== {4'd9, 1'b0, 1'b1, 1'b1}) begin
        $display("FAIL saturate step%0d got %h want %h", k,
                 {q1, w1, o1, t1}, {4'd9, 1'b0, 1'b1, 1'b1});
      end else begin
        n_pass++;
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if ({dq[i], dw[i], dov[i], dtc[i]} !== exp_vec(i)) begin
          $display("FAIL sat_model inst%0d got %h want %h",
                   i, {dq[i], dw[i], dov[i], dtc[i]}, exp_vec(i));
        end else begin
          n_pass++;
        end
      end
    end
  endtask

  task automatic test_load_priority();
    cyc(0, 1, 0, 0, 0, 1);
    // Out-of-range load is clamped on MODULO=10 and taken as-is on MODULO=16.
    cyc(0, 0, 1, 13, 0, 1);
    n_checks++;
    if ({q0, q3} !== {4'd9, 4'd13}) begin
      $display("FAIL load_clamp got q0/q3=%h want=%h", {q0, q3}, {4'd9, 4'd13});
    end else begin
      n_pass++;
    end
    // Wrap once so that ovf is set, then load together with en.
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 1, 5, 1, 1);
    n_checks++;
    if ({q0, o0, w0} !== {4'd5, 1'b1, 1'b0}) begin
      $display("FAIL load_wins got q/ovf/wrap=%h want=%h", {q0, o0, w0},
               {4'd5, 1'b1, 1'b0});
    end else begin
      n_pass++;
    end
    cyc(0, 1, 1, 7, 1, 1);
    n_checks++;
    if ({q0, o0, q3, o3} !== {4'd0, 1'b0, 4'd0, 1'b0}) begin
      $display("FAIL clr_over_load got %h want %h", {q0, o0, q3, o3},
               {4'd0, 1'b0, 4'd0, 1'b0});
    end else begin
      n_pass++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({dq[i], dw[i], dov[i], dtc[i]} !== exp_vec(i)) begin
        $display("FAIL load_model inst%0d got %h want %h",
                 i, {dq[i], dw[i], dov[i], dtc[i]}, exp_vec(i));
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic test_prescale();
    bit         en_pat[7] = '{1, 1, 0, 1, 1, 1, 1};
    logic [3:0] q_pat[7]  = '{0, 0, 0, 1, 1, 1, 2};
    cyc(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 0, 0, en_pat[k], 1);
      n_checks++;
      if (q2 !== q_pat[k]) begin
        $display("FAIL prescale edge%0d got q=%0d want=%0d", k + 1, q2, q_pat[k]);
      end else begin
        n_pass++;
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if ({dq[i], dw[i], dov[i], dtc[i]} !== exp_vec(i)) begin
          $display("FAIL pre_model inst%0d got %h want %h",
                   i, {dq[i], dw[i], dov[i], dtc[i]}, exp_vec(i));
        end else begin
          n_pass++;
        end
      end
    end
  endtask

  task automatic test_full_range();
    int wraps;
    wraps = 0;
    cyc(0, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 17; k++) begin
      cyc(0, 0, 0, 0, 1, 1);
      if (w3) wraps++;
      n_checks++;
      if (q3 !== 4'(k % 16)) begin
        $display("FAIL full_range step%0d got q=%0d want=%0d", k, q3, k % 16);
      end else begin
        n_pass++;
      end
    end
    n_checks++;
    if ({wraps, o3} !== {32'd1, 1'b1}) begin
      $display("FAIL full_wraps got wraps=%0d ovf=%b want 1/1", wraps, o3);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if ({dq[i], dw[i], dov[i], dtc[i]} !== exp_vec(i)) begin
          $display("FAIL random cyc%0d inst%0d got %h want %h",
                   k, i, {dq[i], dw[i], dov[i], dtc[i]}, exp_vec(i));
        end else begin
          n_pass++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    // Reset in the middle of a prescale phase leaves no partial step.
    cyc(0, 0, 1, 4, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    n_checks++;
    if ({q2, q0} !== {4'd0, 4'd2}) begin
      $display("FAIL mid_reset got q2/q0=%h want=%h", {q2, q0}, {4'd0, 4'd2});
    end else begin
      n_pass++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({dq[i], dw[i], dov[i], dtc[i]} !== exp_vec(i)) begin
        $display("FAIL b2b_model inst%0d got %h want %h",
                 i, {dq[i], dw[i], dov[i], dtc[i]}, exp_vec(i));
      end else begin
        n_pass++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_down_wrap();
    test_saturate();
    test_load_priority();
    test_prescale();
    test_full_range();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
